// File: rtl/cpu_ctrl_sequencer_pkg.sv
// rtl/cpu_ctrl_sequencer_pkg.sv - opcode, ALU/writeback codes, state encoding and instruction field positions
package cpu_ctrl_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_A = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RA_LSB  = 6;
    localparam int RB_LSB  = 3;
    localparam int IMM_W   = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// rtl/cpu_ctrl_sequencer_if.sv - fetch-to-sequencer instruction handshake
interface cpu_ctrl_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/cpu_ctrl_sequencer_decoder.sv
// rtl/cpu_ctrl_sequencer_decoder.sv - combinational opcode decode; CPU_CTRL_HALT_EN makes opcode 15 a HALT
module cpu_instr_decoder
    import cpu_ctrl_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       writes_rd,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        writes_rd  = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: is_nop = 1'b1;
            OP_ADD: begin alu_op = ALU_ADD;    writes_rd = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB;    writes_rd = 1'b1; end
            OP_AND: begin alu_op = ALU_AND;    writes_rd = 1'b1; end
            OP_OR:  begin alu_op = ALU_OR;     writes_rd = 1'b1; end
            OP_XOR: begin alu_op = ALU_XOR;    writes_rd = 1'b1; end
            OP_LDI: begin wb_sel = WB_IMM;     writes_rd = 1'b1; end
            OP_MOV: begin alu_op = ALU_PASS_A; writes_rd = 1'b1; end
`ifdef CPU_CTRL_HALT_EN
            OP_HALT: is_halt = 1'b1;
`endif
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// rtl/cpu_ctrl_sequencer.sv - multi-cycle decode/control sequencer driving an 8x16 register file (HALT under CPU_CTRL_HALT_EN)
module cpu_ctrl_sequencer
    import cpu_ctrl_sequencer_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_ctrl_sequencer_if.slave  fetch,
    output logic [2:0]           rf_sel_a,
    output logic [2:0]           rf_sel_b,
    output logic [2:0]           rf_wr_addr,
    output logic                 rf_wr_en,
    output logic [2:0]           alu_op,
    output logic [1:0]           wb_sel,
    output logic [N-1:0]         imm_out,
    output logic                 busy,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired_count,
    output logic                 halted
);

    state_t     state;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_wb_sel;
    logic       dec_writes_rd, dec_is_nop, dec_is_halt, dec_is_illegal;
    logic       writes_rd_q, is_nop_q, is_halt_q, is_illegal_q;
    logic [IMM_W-1:0] imm9;

    // Decode straight off the fetch bus so the select outputs are ready in DECODE.
    cpu_instr_decoder u_decoder (
        .opcode     (fetch.instr[OPC_LSB +: 4]),
        .alu_op     (dec_alu_op),
        .wb_sel     (dec_wb_sel),
        .writes_rd  (dec_writes_rd),
        .is_nop     (dec_is_nop),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    assign imm9 = fetch.instr[IMM_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            fetch.instr_ready <= 1'b1;
            rf_sel_a          <= '0;
            rf_sel_b          <= '0;
            rf_wr_addr        <= '0;
            rf_wr_en          <= 1'b0;
            alu_op            <= '0;
            wb_sel            <= '0;
            imm_out           <= '0;
            busy              <= 1'b0;
            illegal           <= 1'b0;
            retired_count     <= '0;
            halted            <= 1'b0;
            writes_rd_q       <= 1'b0;
            is_nop_q          <= 1'b0;
            is_halt_q         <= 1'b0;
            is_illegal_q      <= 1'b0;
        end else begin
            rf_wr_en <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch.instr_valid && fetch.instr_ready) begin
                        rf_sel_a          <= fetch.instr[RA_LSB +: 3];
                        rf_sel_b          <= fetch.instr[RB_LSB +: 3];
                        rf_wr_addr        <= fetch.instr[RD_LSB +: 3];
                        alu_op            <= dec_alu_op;
                        wb_sel            <= dec_wb_sel;
                        imm_out           <= {{(N-IMM_W){imm9[IMM_W-1]}}, imm9};
                        writes_rd_q       <= dec_writes_rd;
                        is_nop_q          <= dec_is_nop;
                        is_halt_q         <= dec_is_halt;
                        is_illegal_q      <= dec_is_illegal;
                        fetch.instr_ready <= 1'b0;
                        busy              <= 1'b1;
                        state             <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_illegal_q) begin
                        illegal           <= 1'b1;
                        fetch.instr_ready <= 1'b1;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end else if (is_halt_q) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else if (writes_rd_q) begin
                        state <= S_EXEC;
                    end else begin
                        // NOP retires here without touching the register file.
                        retired_count     <= retired_count + 1'b1;
                        fetch.instr_ready <= 1'b1;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    rf_wr_en      <= 1'b1;
                    retired_count <= retired_count + 1'b1;
                    state         <= S_WB;
                end
                S_WB: begin
                    fetch.instr_ready <= 1'b1;
                    busy              <= 1'b0;
                    state             <= S_IDLE;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
